// File: rtl/qracc_sram_ctrl.sv
// qracc_sram_ctrl: sequences one SRAM read or write at a time onto the
// analog macro's SRAM control pins (PCH -> WL/WRITE -> SAEN).
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   rq_valid_i/rq_ready_o     request handshake (sampled only when idle)
//   rq_wr_i, addr_i, wr_data_i request kind, row address, write data
//   rd_valid_o, rd_data_o     one-cycle read-return pulse and held read data
//   WL, PCH, WR_DATA, WRITE,  registered analog controls
//   CSEL, SAEN
//   SA_OUT                    sense-amp outputs from the macro
module qracc_sram_ctrl #(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = 2,
  parameter int wlCycles  = 2,
  parameter int saCycles  = 1,
  localparam int AW = (numRows > 1) ? $clog2(numRows) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               rq_wr_i,
  input  logic               rq_valid_i,
  output logic               rq_ready_o,
  output logic               rd_valid_o,
  output logic [numCols-1:0] rd_data_o,
  input  logic [numCols-1:0] wr_data_i,
  input  logic [AW-1:0]      addr_i,
  output logic [numRows-1:0] WL,
  output logic               PCH,
  output logic [numCols-1:0] WR_DATA,
  output logic               WRITE,
  output logic [numCols-1:0] CSEL,
  output logic               SAEN,
  input  logic [numCols-1:0] SA_OUT
);

  localparam int MAXC = (pchCycles > wlCycles) ?
                        ((pchCycles > saCycles) ? pchCycles : saCycles) :
                        ((wlCycles > saCycles) ? wlCycles : saCycles);
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] PCH_LAST = CW'(pchCycles - 1);
  localparam logic [CW-1:0] WL_LAST  = CW'(wlCycles - 1);
  localparam logic [CW-1:0] SA_LAST  = CW'(saCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRECH   = 3'd1,
    S_ACCESS  = 3'd2,
    S_SENSE   = 3'd3,
    S_RECOVER = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [numCols-1:0] data_q, data_d;

  logic               rq_ready_q, rq_ready_d;
  logic               rd_valid_q, rd_valid_d;
  logic [numCols-1:0] rd_data_q, rd_data_d;
  logic [numRows-1:0] wl_q, wl_d;
  logic               pch_q, pch_d;
  logic [numCols-1:0] wr_drv_q, wr_drv_d;
  logic               write_q, write_d;
  logic [numCols-1:0] csel_q, csel_d;
  logic               saen_q, saen_d;

  logic [numRows-1:0] wl_onehot_s;
  logic               addr_ok_s;

  // Decoder: an address with no matching row yields an all-zero wordline.
  function automatic logic [numRows-1:0] row_onehot(input logic [AW-1:0] a);
    logic [numRows-1:0] oh;
    for (int i = 0; i < numRows; i++) begin
      oh[i] = (a == AW'(i));
    end
    return oh;
  endfunction

  assign wl_onehot_s = row_onehot(addr_q);
  assign addr_ok_s   = |wl_onehot_s;

  // State, phase counter, latched request and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      rq_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wl_q       <= '0;
      pch_q      <= 1'b0;
      wr_drv_q   <= '0;
      write_q    <= 1'b0;
      csel_q     <= '0;
      saen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      rq_ready_q <= rq_ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wl_q       <= wl_d;
      pch_q      <= pch_d;
      wr_drv_q   <= wr_drv_d;
      write_q    <= write_d;
      csel_q     <= csel_d;
      saen_q     <= saen_d;
    end
  end

  // Next state, phase counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        // rq_ready_q is high exactly while idle, so this is the handshake.
        if (rq_valid_i && rq_ready_q) begin
          addr_d  = addr_i;
          wr_d    = rq_wr_i;
          data_d  = wr_data_i;
          cnt_d   = '0;
          state_d = S_PRECH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRECH: begin
        if (cnt_q == PCH_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACCESS: begin
        if (cnt_q == WL_LAST) begin
          cnt_d   = '0;
          state_d = wr_q ? S_RECOVER : S_SENSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SENSE: begin
        if (cnt_q == SA_LAST) begin
          cnt_d   = '0;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every pin is a flop aligned with
  // the state it belongs to.
  always_comb begin
    rq_ready_d = (state_d == S_IDLE);
    rd_valid_d = 1'b0;
    wl_d       = '0;
    pch_d      = 1'b0;
    wr_drv_d   = '0;
    write_d    = 1'b0;
    csel_d     = '0;
    saen_d     = 1'b0;
    case (state_d)
      S_PRECH: begin
        pch_d = 1'b1;
      end
      S_ACCESS: begin
        wl_d   = wl_onehot_s;
        csel_d = '1;
        if (wr_q) begin
          write_d  = 1'b1;
          wr_drv_d = data_q;
        end else begin
          write_d  = 1'b0;
          wr_drv_d = '0;
        end
      end
      S_SENSE: begin
        wl_d   = wl_onehot_s;
        csel_d = '1;
        saen_d = 1'b1;
      end
      S_RECOVER: begin
        rd_valid_d = ~wr_q;
      end
      default: begin
        rd_valid_d = 1'b0;
      end
    endcase
    // Capture on the last sense cycle; a row that does not exist reads as 0.
    if ((state_q == S_SENSE) && (cnt_q == SA_LAST)) begin
      rd_data_d = addr_ok_s ? SA_OUT : '0;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  assign rq_ready_o = rq_ready_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign WL         = wl_q;
  assign PCH        = pch_q;
  assign WR_DATA    = wr_drv_q;
  assign WRITE      = write_q;
  assign CSEL       = csel_q;
  assign SAEN       = saen_q;

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
module tb_qracc_sram_ctrl;

  localparam int P = 2;
  localparam int W = 2;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         nrst = 1'b1;
  logic         rq_wr_i = 1'b0, rq_valid_i = 1'b0;
  logic         rq_ready_o, rd_valid_o;
  logic [31:0]  rd_data_o, wr_data_i = 32'h0;
  logic [6:0]   addr_i = 7'd0;
  logic [127:0] wl;
  logic         pch, write, saen;
  logic [31:0]  wr_data_o, csel, sa_out;
  logic [31:0]  sa_junk = 32'h0;

  // second instance with non-default phase lengths
  logic         rq_valid2 = 1'b0;
  logic         rq_ready2, rd_valid2, pch2, write2, saen2;
  logic [31:0]  rd_data2, wr_data2, csel2, sa_out2;
  logic [127:0] wl2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit          rd;
    int          addr;
    logic [31:0] data;
    int          h;
  } txn_t;
  txn_t q[$];

  bit   [31:0] sram    [128];   // macro model, written only via DUT pins
  bit   [31:0] ref_mem [128];   // reference contents, updated at handshake
  logic [31:0] last_rd = 32'h0;

  qracc_sram_ctrl u_dut (
    .clk(clk), .nrst(nrst), .rq_wr_i(rq_wr_i), .rq_valid_i(rq_valid_i),
    .rq_ready_o(rq_ready_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .wr_data_i(wr_data_i), .addr_i(addr_i), .WL(wl), .PCH(pch),
    .WR_DATA(wr_data_o), .WRITE(write), .CSEL(csel), .SAEN(saen), .SA_OUT(sa_out)
  );

  qracc_sram_ctrl #(.pchCycles(1), .wlCycles(3), .saCycles(2)) u_dut2 (
    .clk(clk), .nrst(nrst), .rq_wr_i(1'b0), .rq_valid_i(rq_valid2),
    .rq_ready_o(rq_ready2), .rd_valid_o(rd_valid2), .rd_data_o(rd_data2),
    .wr_data_i(32'h0), .addr_i(7'd64), .WL(wl2), .PCH(pch2),
    .WR_DATA(wr_data2), .WRITE(write2), .CSEL(csel2), .SAEN(saen2), .SA_OUT(sa_out2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int row_of(input logic [127:0] w);
    int r = 0;
    for (int i = 0; i < 128; i++) if (w[i]) r = i;
    return r;
  endfunction

  // Sense amps return the selected row while enabled, garbage otherwise.
  assign sa_out  = saen ? sram[row_of(wl)] : sa_junk;
  assign sa_out2 = saen2 ? 32'h5EED_0040 : 32'h0BAD_0BAD;

  // Macro array: a write lands wherever WL and WRITE point.
  always @(posedge clk) begin
    sa_junk <= $urandom;
    if (write) begin
      for (int r = 0; r < 128; r++) if (wl[r]) sram[r] <= wr_data_o;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int end_k(input txn_t t);
    return t.rd ? (P + W + S + 1) : (P + W + 1);
  endfunction

  // Monitor: per cycle, derive every pin from the front transaction's age.
  task automatic check_cycle();
    int k;
    bit rd;
    logic [127:0] e_wl = '0;
    logic e_pch = 1'b0, e_write = 1'b0, e_saen = 1'b0, e_rdv = 1'b0, e_rdy = 1'b1;
    logic [31:0] e_wd = 32'h0, e_csel = 32'h0;
    while (q.size() > 0 && cyc > q[0].h + end_k(q[0])) void'(q.pop_front());
    if (q.size() > 0) begin
      k  = cyc - q[0].h;
      rd = q[0].rd;
      e_rdy = (k == 0);
      e_pch = (k >= 1 && k <= P);
      if (k >= P + 1 && k <= P + W + (rd ? S : 0)) begin
        e_wl[q[0].addr] = 1'b1;
        e_csel = 32'hFFFF_FFFF;
      end
      if (!rd && k >= P + 1 && k <= P + W) begin
        e_write = 1'b1;
        e_wd    = q[0].data;
      end
      e_saen = rd && (k >= P + W + 1) && (k <= P + W + S);
      if (rd && k == P + W + S + 1) begin
        e_rdv   = 1'b1;
        last_rd = q[0].data;
      end
    end
    check("ready", rq_ready_o, e_rdy);
    check("pch", pch, e_pch);
    check("wl", wl, e_wl);
    check("csel", csel, e_csel);
    check("write", write, e_write);
    check("wr_data", wr_data_o, e_wd);
    check("saen", saen, e_saen);
    check("rd_valid", rd_valid_o, e_rdv);
    check("rd_data", rd_data_o, last_rd);
    check("ovl_pch_wl", pch && (wl != '0), 1'b0);
    check("ovl_saen_write", saen && write, 1'b0);
    check("wl_onehot", $countones(wl) <= 1, 1'b1);
  endtask

  always @(negedge clk) begin
    #1;
    if (mon_en) check_cycle();
  end

  // Present a request, wait for acceptance, push the expected response.
  task automatic issue(input bit wr, input int addr, input logic [31:0] data, output int hs);
    bit got = 1'b0;
    txn_t t;
    hs = -1;
    rq_wr_i = wr; addr_i = 7'(addr); wr_data_i = data; rq_valid_i = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rq_ready_o) got = 1'b1;
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout: got no ready expected ready within 40 cycles");
    end else begin
      hs = cyc;
      t.rd = !wr; t.addr = addr; t.h = cyc;
      t.data = wr ? data : ref_mem[addr];
      if (wr) ref_mem[addr] = data;
      q.push_back(t);
    end
    @(posedge clk); #1;
    // scramble inputs: the latched copies must be what the DUT uses
    rq_valid_i = 1'b0; rq_wr_i = 1'($urandom); addr_i = 7'($urandom); wr_data_i = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, rq_ready_o, 1'b1);
    check({tag, "_rdv"},   rd_valid_o, 1'b0);
    check({tag, "_rdd"},   rd_data_o, 32'h0);
    check({tag, "_wl"},    wl, 128'h0);
    check({tag, "_pch"},   pch, 1'b0);
    check({tag, "_wd"},    wr_data_o, 32'h0);
    check({tag, "_write"}, write, 1'b0);
    check({tag, "_csel"},  csel, 32'h0);
    check({tag, "_saen"},  saen, 1'b0);
  endtask

  initial begin
    int h1, h2, hs;
    bit got;
    logic [127:0] e2;
    #1 nrst = 1'b0;
    #2 check_reset_vals("rst");
    repeat (3) @(posedge clk);
    @(negedge clk); #3 nrst = 1'b1;
    @(posedge clk); #2 mon_en = 1'b1;
    @(posedge clk); #1;

    // directed write then read of row 5
    issue(1'b1, 5, 32'hA5A5_1234, hs);
    issue(1'b0, 5, 32'h0, hs);
    repeat (2) @(posedge clk); #1;

    // back-to-back with valid held high
    issue(1'b1, 0, 32'h1357_9BDF, h1);
    issue(1'b0, 127, 32'h0, h2);
    check("b2b_handshake_gap", h2 - h1, 6);
    issue(1'b0, 0, 32'h0, hs);

    // preload rows 0..15, then random traffic over them
    for (int a = 0; a < 16; a++) issue(1'b1, a, $urandom, hs);
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, hs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset in the sense cycle of a read: pulse must be dropped
    issue(1'b0, 3, 32'h0, hs);
    for (int i = 0; i < 20 && cyc < hs + P + W + S; i++) @(negedge clk);
    #3 mon_en = 1'b0; nrst = 1'b0;
    #1 check_reset_vals("midrst");
    q.delete();
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #3 nrst = 1'b1;
    @(posedge clk); #2 mon_en = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3, 32'h0, hs);
    issue(1'b1, 9, 32'hCAFE_F00D, hs);
    issue(1'b0, 9, 32'h0, hs);
    repeat (10) @(posedge clk); #1;

    // pchCycles=1, wlCycles=3, saCycles=2 read of row 64
    e2 = '0; e2[64] = 1'b1;
    rq_valid2 = 1'b1; got = 1'b0; h1 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rq_ready2) begin got = 1'b1; h1 = cyc; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL p2_handshake: got no ready expected ready");
    end
    @(posedge clk); #1 rq_valid2 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #2;
      check("p2_wl", wl2, ((cyc - h1) >= 2 && (cyc - h1) <= 6) ? e2 : 128'h0);
      check("p2_rd_valid", rd_valid2, (cyc - h1) == 7);
      check("p2_ready", rq_ready2, (cyc - h1) >= 8);
      if ((cyc - h1) == 7) check("p2_rd_data", rd_data2, 32'h5EED_0040);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
